// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte sources, with message lock and a tx_done watchdog.
// Optional: define TX_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (index 0 highest).
module uart_tx_arbiter #(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 20000,
    localparam int OW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   req_last,
    input  logic [8*N_REQ-1:0] req_byte,
    output logic [N_REQ-1:0]   ack,
    input  logic               tx_done,
    output logic [7:0]         out_byte,
    output logic               uart_tx_go,
    output logic               busy,
    output logic [OW-1:0]      owner,
    output logic               locked,
    output logic               tx_timeout
);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [WW-1:0]    wdog_q, wdog_d;
    logic [7:0]       byte_d;
    logic             go_d;
    logic [N_REQ-1:0] ack_d;
    logic             busy_d;
    logic [OW-1:0]    owner_d;
    logic             locked_d;
    logic             tout_d;
    logic             gnt_any;
    logic [OW-1:0]    gnt_idx;
    logic [7:0]       sel_byte;
    logic             sel_last;
    logic             wdog_hit;
`ifdef TX_ARB_RR_EN
    logic [OW-1:0]    rr_q, rr_d;
`endif

    assign wdog_hit = (wdog_q == WW'(TIMEOUT - 1));

    // A held lock restricts the candidate set to the current owner.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (locked) begin
            gnt_any = req[owner];
            gnt_idx = owner;
        end else begin
`ifdef TX_ARB_RR_EN
            for (int k = N_REQ - 1; k >= 0; k--) begin
                if (req[(int'(rr_q) + k) % N_REQ]) begin
                    gnt_any = 1'b1;
                    gnt_idx = OW'((int'(rr_q) + k) % N_REQ);
                end
            end
`else
            for (int k = N_REQ - 1; k >= 0; k--) begin
                if (req[k]) begin
                    gnt_any = 1'b1;
                    gnt_idx = OW'(k);
                end
            end
`endif
        end
    end

    always_comb begin
        sel_byte = '0;
        sel_last = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_idx == OW'(k)) begin
                sel_byte = req_byte[8*k +: 8];
                sel_last = req_last[k];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        wdog_d   = wdog_q;
        byte_d   = out_byte;
        go_d     = 1'b0;
        ack_d    = '0;
        busy_d   = busy;
        owner_d  = owner;
        locked_d = locked;
        tout_d   = 1'b0;
`ifdef TX_ARB_RR_EN
        rr_d     = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    byte_d   = sel_byte;
                    go_d     = 1'b1;
                    ack_d    = N_REQ'(1) << gnt_idx;
                    owner_d  = gnt_idx;
                    busy_d   = 1'b1;
                    locked_d = !sel_last;
                    wdog_d   = '0;
                    state_d  = BUSY;
`ifdef TX_ARB_RR_EN
                    if (!locked) begin
                        rr_d = (gnt_idx == OW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    end
`endif
                end else if (locked) begin
                    // Owner went quiet mid-message; release the lock if it stays quiet too long.
                    if (wdog_hit) begin
                        tout_d   = 1'b1;
                        locked_d = 1'b0;
                        wdog_d   = '0;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end else begin
                    wdog_d = '0;
                end
            end
            BUSY: begin
                // tx_done in the go cycle belongs to nothing we started, so it is ignored.
                if (!uart_tx_go && tx_done) begin
                    busy_d  = 1'b0;
                    wdog_d  = '0;
                    state_d = IDLE;
                end else if (wdog_hit) begin
                    tout_d   = 1'b1;
                    busy_d   = 1'b0;
                    locked_d = 1'b0;
                    wdog_d   = '0;
                    state_d  = IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wdog_q     <= '0;
            out_byte   <= '0;
            uart_tx_go <= 1'b0;
            ack        <= '0;
            busy       <= 1'b0;
            owner      <= '0;
            locked     <= 1'b0;
            tx_timeout <= 1'b0;
        end else begin
            state_q    <= state_d;
            wdog_q     <= wdog_d;
            out_byte   <= byte_d;
            uart_tx_go <= go_d;
            ack        <= ack_d;
            busy       <= busy_d;
            owner      <= owner_d;
            locked     <= locked_d;
            tx_timeout <= tout_d;
        end
    end

`ifdef TX_ARB_RR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues, a UART tx_done model, and per-scenario tasks.
module tb_uart_tx_arbiter;
    localparam int N_REQ   = 3;
    localparam int TIMEOUT = 50;
    localparam int OW      = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   req_last;
    logic [8*N_REQ-1:0] req_byte;
    logic [N_REQ-1:0]   ack;
    logic               tx_done;
    logic [7:0]         out_byte;
    logic               uart_tx_go;
    logic               busy;
    logic [OW-1:0]      owner;
    logic               locked;
    logic               tx_timeout;

    int tests = 0;
    int fails = 0;

    // Source queues hold {last, byte}; expected queue holds {idx, last, byte}.
    logic [8:0]  srcq [N_REQ][$];
    logic [10:0] expq [$];
    logic [10:0] e;

    int cyc = 0;
    int gos = 0;
    int tcount = 0;
    int done_cnt = 0;
    int done_delay = 10;
    int release_cyc = 0;
    int last_go_cyc = 0;
    int last_gap = 0;
    int last_lat = 0;
    int to_since_go = 0;
    int to_gap = 0;
    int req_since [N_REQ];
    logic prev_busy = 1'b0;
    logic expect_timeout = 1'b0;

    uart_tx_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_last(req_last), .req_byte(req_byte),
        .ack(ack), .tx_done(tx_done), .out_byte(out_byte), .uart_tx_go(uart_tx_go),
        .busy(busy), .owner(owner), .locked(locked), .tx_timeout(tx_timeout)
    );

    always #5 clk = ~clk;

    // UART model, scoreboard monitor and requester agents, all evaluated on the falling edge.
    initial begin : env
        req = '0;
        req_last = '0;
        req_byte = '0;
        tx_done = 1'b0;
        for (int i = 0; i < N_REQ; i++) req_since[i] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            tx_done = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) tx_done = 1'b1;
            end
            if (prev_busy && !busy) release_cyc = cyc;
            prev_busy = busy;
            if (uart_tx_go === 1'b1) begin
                gos++;
                done_cnt = done_delay;
                last_gap = cyc - release_cyc;
                last_go_cyc = cyc;
                tests++;
                if (expq.size() == 0) begin
                    fails++;
                    $display("FAIL go_unexpected: got byte %h, required no go", out_byte);
                end else begin
                    e = expq.pop_front();
                    last_lat = cyc - req_since[e[10:9]];
                    tests++;
                    if (out_byte !== e[7:0]) begin
                        fails++;
                        $display("FAIL out_byte: got %h, required %h", out_byte, e[7:0]);
                    end
                    tests++;
                    if (ack !== (N_REQ'(1) << e[10:9])) begin
                        fails++;
                        $display("FAIL ack: got %b, required one-hot index %0d", ack, e[10:9]);
                    end
                    tests++;
                    if (owner !== e[10:9]) begin
                        fails++;
                        $display("FAIL owner: got %0d, required %0d", owner, e[10:9]);
                    end
                    tests++;
                    if (locked !== ~e[8] || busy !== 1'b1) begin
                        fails++;
                        $display("FAIL lock_busy_at_go: got locked=%b busy=%b, required locked=%b busy=1",
                                 locked, busy, ~e[8]);
                    end
                end
            end else begin
                tests++;
                if (ack !== '0) begin
                    fails++;
                    $display("FAIL ack_without_go: got %b, required 0", ack);
                end
            end
            if (tx_timeout === 1'b1) begin
                tcount++;
                to_since_go = cyc - last_go_cyc;
                to_gap = cyc - release_cyc;
                tests++;
                if (!expect_timeout || busy !== 1'b0 || locked !== 1'b0) begin
                    fails++;
                    $display("FAIL timeout_pulse: got expected=%b busy=%b locked=%b, required expected=1 busy=0 locked=0",
                             expect_timeout, busy, locked);
                end
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (ack[i] === 1'b1 && srcq[i].size() > 0) void'(srcq[i].pop_front());
                if (srcq[i].size() > 0) begin
                    if (!req[i]) req_since[i] = cyc;
                    req[i] = 1'b1;
                    req_last[i] = srcq[i][0][8];
                    req_byte[8*i +: 8] = srcq[i][0][7:0];
                end else begin
                    req[i] = 1'b0;
                    req_last[i] = 1'b0;
                end
            end
        end
    end

    function automatic bit all_src_empty();
        for (int i = 0; i < N_REQ; i++) if (srcq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (!(expq.size() == 0 && all_src_empty() && busy === 1'b0 && done_cnt == 0 && req === '0)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL %s_drain: got %0d bytes outstanding after %0d cycles, required 0", name, expq.size(), budget);
        end
    endtask

    task automatic wait_go(input string name, input int budget);
        int start = gos;
        int n = 0;
        while (gos == start && n < budget) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (gos == start) begin
            fails++;
            $display("FAIL %s: got no go in %0d cycles, required one", name, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({out_byte, uart_tx_go, ack, busy, owner, locked, tx_timeout} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got byte=%h go=%b ack=%b busy=%b owner=%0d locked=%b to=%b, required all 0",
                     out_byte, uart_tx_go, ack, busy, owner, locked, tx_timeout);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || uart_tx_go !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: got busy=%b go=%b, required 0 0", busy, uart_tx_go);
        end
    endtask

    task automatic test_single_byte();
        done_delay = 10;
        srcq[1].push_back({1'b1, 8'h41});
        expq.push_back({2'd1, 1'b1, 8'h41});
        drain("t1", 100);
        tests++;
        if (last_lat !== 1) begin
            fails++;
            $display("FAIL t1_latency: got %0d cycles, required 1", last_lat);
        end
        tests++;
        if (release_cyc - last_go_cyc !== 11) begin
            fails++;
            $display("FAIL t1_busy_len: got %0d cycles, required 11", release_cyc - last_go_cyc);
        end
        tests++;
        if (locked !== 1'b0 || owner !== 2'd1) begin
            fails++;
            $display("FAIL t1_final: got locked=%b owner=%0d, required 0 1", locked, owner);
        end
    endtask

    task automatic test_contention();
        done_delay = 10;
        srcq[0].push_back({1'b1, 8'h30});
        srcq[2].push_back({1'b1, 8'h32});
`ifdef TX_ARB_RR_EN
        expq.push_back({2'd2, 1'b1, 8'h32});
        expq.push_back({2'd0, 1'b1, 8'h30});
`else
        expq.push_back({2'd0, 1'b1, 8'h30});
        expq.push_back({2'd2, 1'b1, 8'h32});
`endif
        drain("t2", 200);
        tests++;
        if (last_gap !== 1) begin
            fails++;
            $display("FAIL t2_gap: got %0d cycles between release and go, required 1", last_gap);
        end
    endtask

    task automatic test_lock();
        int n = 0;
        done_delay = 6;
        srcq[1].push_back({1'b0, 8'h48});
        srcq[1].push_back({1'b0, 8'h49});
        srcq[1].push_back({1'b1, 8'h0a});
        expq.push_back({2'd1, 1'b0, 8'h48});
        expq.push_back({2'd1, 1'b0, 8'h49});
        expq.push_back({2'd1, 1'b1, 8'h0a});
        expq.push_back({2'd0, 1'b1, 8'h5a});
        while (expq.size() > 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        srcq[0].push_back({1'b1, 8'h5a});
        @(negedge clk);
        tests++;
        if (locked !== 1'b1 || owner !== 2'd1) begin
            fails++;
            $display("FAIL t3_locked: got locked=%b owner=%0d, required 1 1", locked, owner);
        end
        drain("t3", 300);
    endtask

    task automatic test_watchdog();
        int t0 = tcount;
        done_delay = 0;
        expect_timeout = 1'b1;
        srcq[2].push_back({1'b1, 8'h41});
        expq.push_back({2'd2, 1'b1, 8'h41});
        wait_go("t4_go", 20);
        done_delay = 10;
        srcq[0].push_back({1'b1, 8'h42});
        expq.push_back({2'd0, 1'b1, 8'h42});
        drain("t4", 300);
        expect_timeout = 1'b0;
        tests++;
        if (tcount - t0 !== 1) begin
            fails++;
            $display("FAIL t4_count: got %0d timeouts, required 1", tcount - t0);
        end
        tests++;
        if (last_gap !== 1) begin
            fails++;
            $display("FAIL t4_next_grant: got gap %0d, required 1", last_gap);
        end
    endtask

    task automatic test_stalled_lock();
        int t0 = tcount;
        done_delay = 10;
        expect_timeout = 1'b1;
        srcq[1].push_back({1'b0, 8'h50});
        expq.push_back({2'd1, 1'b0, 8'h50});
        wait_go("t5_go", 20);
        srcq[2].push_back({1'b1, 8'h51});
        expq.push_back({2'd2, 1'b1, 8'h51});
        drain("t5", 300);
        expect_timeout = 1'b0;
        tests++;
        if (tcount - t0 !== 1) begin
            fails++;
            $display("FAIL t5_count: got %0d timeouts, required 1", tcount - t0);
        end
        tests++;
        if (to_gap !== TIMEOUT) begin
            fails++;
            $display("FAIL t5_idle_cycles: got %0d, required %0d", to_gap, TIMEOUT);
        end
    endtask

    task automatic check_wd_latency();
        tests++;
        if (to_since_go !== TIMEOUT) begin
            fails++;
            $display("FAIL t4_latency: got %0d cycles after go, required %0d", to_since_go, TIMEOUT);
        end
    endtask

    task automatic test_reset_mid_busy();
        int g0;
        done_delay = 10;
        srcq[0].push_back({1'b1, 8'h52});
        expq.push_back({2'd0, 1'b1, 8'h52});
        wait_go("t6_go", 20);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        tests++;
        if ({out_byte, uart_tx_go, ack, busy, owner, locked, tx_timeout} !== '0) begin
            fails++;
            $display("FAIL t6_async_reset: got byte=%h go=%b busy=%b owner=%0d locked=%b, required all 0",
                     out_byte, uart_tx_go, busy, owner, locked);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        g0 = gos;
        repeat (10) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || gos !== g0) begin
            fails++;
            $display("FAIL t6_stray_done: got busy=%b gos=%0d, required 0 %0d", busy, gos, g0);
        end
        srcq[1].push_back({1'b1, 8'h53});
        expq.push_back({2'd1, 1'b1, 8'h53});
        drain("t6", 100);
        tests++;
        if (owner !== 2'd1 || locked !== 1'b0) begin
            fails++;
            $display("FAIL t6_after: got owner=%0d locked=%b, required 1 0", owner, locked);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_contention();
        test_lock();
        test_watchdog();
        check_wd_latency();
        test_stalled_lock();
        test_reset_mid_busy();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit: got no finish by 100000, required finish");
        $fatal(1, "time limit");
    end
endmodule
